// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified instruction/data RAM between the IF stage
// (instruction fetch) and the MEM stage (load/store). Requests are granted
// only while idle, with data accesses taking priority over fetches. Stores
// complete in the cycle they issue. Loads and fetches wait MEM_LATENCY cycles
// for read data, which a small down-counter tracks. A fetch that is flushed
// while in flight still completes on the RAM, but its data is dropped.
//
// Handshake: a requester raises its request (i_if_req, i_mem_read,
// i_mem_write) and holds it, with stable address and data, until the matching
// one-cycle valid pulse (o_if_valid / o_mem_valid). A fetch may instead be
// abandoned by i_if_flush. The valid pulse is the only acknowledgement, and a
// request that is still high in the cycle after its pulse counts as a new
// request.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_if_req/i_if_addr    fetch request and address
//   i_if_flush            IF/ID flush; drops the fetch currently in flight
//   o_if_rdata/o_if_valid fetched instruction and completion pulse
//   i_mem_read/i_mem_write/i_mem_addr/i_mem_wdata  data request
//   o_mem_rdata/o_mem_valid                        load data, completion pulse
//   o_ram_en/o_ram_we/o_ram_addr/o_ram_wdata/i_ram_rdata  RAM port
//   o_pipe_stall          freeze IF..MEM while a data access is pending
//   o_pc_keep             hold PC and IF/ID
//   o_dbg_state           current FSM state (0 idle, 1 fetch busy, 2 load busy)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_if_flush,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_valid,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] o_mem_rdata,
  output logic              o_mem_valid,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic              o_pipe_stall,
  output logic              o_pc_keep,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2
  } state_e;

  // The counter reaches zero in the cycle the RAM presents read data.
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              discard_q, discard_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      discard_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      discard_q   <= discard_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    discard_d   = discard_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    o_ram_en    = 1'b0;
    o_ram_we    = 1'b0;
    o_if_valid  = 1'b0;
    o_mem_valid = 1'b0;

    // Reset blocks every issue and every completion, whatever the requests.
    if (!i_reset) begin
      case (state_q)
        S_IDLE: begin
          // Store beats load beats fetch; read+write together is a store.
          if (i_mem_write) begin
            o_ram_en    = 1'b1;
            o_ram_we    = 1'b1;
            o_mem_valid = 1'b1;
            ram_addr_d  = i_mem_addr;
            ram_wdata_d = i_mem_wdata;
          end else if (i_mem_read) begin
            o_ram_en   = 1'b1;
            ram_addr_d = i_mem_addr;
            cnt_d      = CNT_LOAD;
            state_d    = S_BUSY_D;
          end else if (i_if_req) begin
            o_ram_en   = 1'b1;
            ram_addr_d = i_if_addr;
            cnt_d      = CNT_LOAD;
            discard_d  = i_if_flush;
            state_d    = S_BUSY_I;
          end
        end
        S_BUSY_I: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
            if (i_if_flush) discard_d = 1'b1;
          end else begin
            state_d   = S_IDLE;
            discard_d = 1'b0;
            // A flush anywhere in the fetch's lifetime drops its data.
            if (!discard_q && !i_if_flush) begin
              o_if_valid = 1'b1;
              if_rdata_d = i_ram_rdata;
            end
          end
        end
        S_BUSY_D: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d     = S_IDLE;
            o_mem_valid = 1'b1;
            mem_rdata_d = i_ram_rdata;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // The next-state values double as outputs, so read data appears in the
  // same cycle as its valid pulse and is then held by the register.
  assign o_ram_addr  = ram_addr_d;
  assign o_ram_wdata = ram_wdata_d;
  assign o_if_rdata  = if_rdata_d;
  assign o_mem_rdata = mem_rdata_d;

  assign o_pipe_stall = (i_mem_read | i_mem_write) & ~o_mem_valid;
  assign o_pc_keep    = o_pipe_stall | (i_if_req & ~o_if_valid);
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req, if_flush, mem_read, mem_write;
  logic [31:0] if_addr, mem_addr, mem_wdata, ram_rdata;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
  logic        if_valid, mem_valid, ram_en, ram_we, pipe_stall, pc_keep;
  logic [1:0]  dbg_state;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
    .o_if_rdata(if_rdata), .o_if_valid(if_valid),
    .i_mem_read(mem_read), .i_mem_write(mem_write), .i_mem_addr(mem_addr),
    .i_mem_wdata(mem_wdata), .o_mem_rdata(mem_rdata), .o_mem_valid(mem_valid),
    .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
    .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata),
    .o_pipe_stall(pipe_stall), .o_pc_keep(pc_keep), .o_dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------- counters
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int idx(input logic [31:0] a);
    return int'(a[5:2]);
  endfunction

  // ---------------------------------------------------------------- RAM model
  // Write lands at the end of the store cycle; read data is visible exactly
  // LAT cycles after the issue cycle and is random junk at all other times.
  logic [31:0] ram_mem [16];
  logic        en_s = 1'b0, we_s = 1'b0;
  logic [31:0] addr_s = '0, wdata_s = '0, paddr = '0;
  int          pend = 0;

  always @(negedge clk) begin
    en_s    = ram_en;
    we_s    = ram_we;
    addr_s  = ram_addr;
    wdata_s = ram_wdata;
  end

  always @(posedge clk) begin
    #1;
    if (en_s && we_s) ram_mem[idx(addr_s)] = wdata_s;
    if (en_s && !we_s) begin
      pend  = LAT;
      paddr = addr_s;
    end else if (pend > 0) begin
      pend--;
    end
    ram_rdata = (pend == 1) ? ram_mem[idx(paddr)] : $urandom;
  end

  // ---------------------------------------------------------------- reference model
  // Port is free or busy until a known completion cycle; the expected read
  // data for the outstanding access sits in exp_q.
  logic [31:0] ref_mem [16];
  logic [31:0] exp_q [$];
  bit          mon_en = 1'b0;
  bit          busy = 1'b0, is_load = 1'b0, flushed = 1'b0;
  int          done_cyc = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_if = '0, m_mem = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      logic        e_en, e_we, e_iv, e_mv, e_stall, e_keep;
      logic [31:0] e_addr, e_wd, e_ird, e_mrd;
      e_en = 0; e_we = 0; e_iv = 0; e_mv = 0;
      e_addr = m_addr; e_wd = m_wdata; e_ird = m_if; e_mrd = m_mem;
      if (!rst) begin
        if (!busy) begin
          if (mem_write) begin
            e_en = 1; e_we = 1; e_mv = 1; e_addr = mem_addr; e_wd = mem_wdata;
          end else if (mem_read) begin
            e_en = 1; e_addr = mem_addr;
          end else if (if_req) begin
            e_en = 1; e_addr = if_addr;
          end
        end else if (cyc == done_cyc) begin
          if (is_load) begin
            e_mv = 1; e_mrd = exp_q[0];
          end else if (!(flushed || if_flush)) begin
            e_iv = 1; e_ird = exp_q[0];
          end
        end
      end
      e_stall = (mem_read | mem_write) & ~e_mv;
      e_keep  = e_stall | (if_req & ~e_iv);
      chk("mdl_ram_en", ram_en, e_en);
      chk("mdl_ram_we", ram_we, e_we);
      chk("mdl_ram_addr", ram_addr, e_addr);
      chk("mdl_ram_wdata", ram_wdata, e_wd);
      chk("mdl_if_valid", if_valid, e_iv);
      chk("mdl_mem_valid", mem_valid, e_mv);
      chk("mdl_if_rdata", if_rdata, e_ird);
      chk("mdl_mem_rdata", mem_rdata, e_mrd);
      chk("mdl_pipe_stall", pipe_stall, e_stall);
      chk("mdl_pc_keep", pc_keep, e_keep);
      // advance model to the next cycle
      if (rst) begin
        busy = 0; m_addr = '0; m_wdata = '0; m_if = '0; m_mem = '0;
        exp_q.delete();
      end else if (!busy) begin
        if (mem_write) begin
          m_addr = mem_addr; m_wdata = mem_wdata; ref_mem[idx(mem_addr)] = mem_wdata;
        end else if (mem_read) begin
          busy = 1; is_load = 1; done_cyc = cyc + LAT; m_addr = mem_addr;
          exp_q.push_back(ref_mem[idx(mem_addr)]);
        end else if (if_req) begin
          busy = 1; is_load = 0; flushed = if_flush; done_cyc = cyc + LAT; m_addr = if_addr;
          exp_q.push_back(ref_mem[idx(if_addr)]);
        end
      end else begin
        if (!is_load && if_flush) flushed = 1;
        if (cyc == done_cyc) begin
          busy = 0;
          if (e_mv) m_mem = e_mrd;
          if (e_iv) m_if = e_ird;
          void'(exp_q.pop_front());
        end
      end
    end
    cyc++;
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    if_req = 0; if_flush = 0; mem_read = 0; mem_write = 0;
  endtask

  task automatic settle(input int n);
    clear_reqs();
    repeat (n) step();
  endtask

  typedef struct {
    logic        if_req, rd, wr, flush;
    logic        e_en, e_we, e_mv, e_stall, e_keep;
    logic [31:0] e_addr;
  } vec_t;

  localparam logic [31:0] IF_A  = 32'h0000_0084;
  localparam logic [31:0] MEM_A = 32'h0000_0038;
  localparam logic [31:0] FA    = 32'h0000_0008;
  localparam logic [31:0] LA    = 32'h0000_0024;

  vec_t vecs[8];
  bit   saw_mv, saw_iv, d_act, f_act;

  initial begin
    vecs[0] = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 32'h0};
    vecs[1] = '{1, 0, 0, 0,  1, 0, 0, 0, 1, IF_A};
    vecs[2] = '{0, 1, 0, 0,  1, 0, 0, 1, 1, MEM_A};
    vecs[3] = '{0, 0, 1, 0,  1, 1, 1, 0, 0, MEM_A};
    vecs[4] = '{0, 1, 1, 0,  1, 1, 1, 0, 0, MEM_A};
    vecs[5] = '{1, 0, 1, 0,  1, 1, 1, 0, 1, MEM_A};
    vecs[6] = '{1, 1, 0, 0,  1, 0, 0, 1, 1, MEM_A};
    vecs[7] = '{1, 0, 0, 1,  1, 0, 0, 0, 1, IF_A};

    for (int i = 0; i < 16; i++) begin
      ram_mem[i] = $urandom;
      ref_mem[i] = ram_mem[i];
    end
    ram_mem[idx(32'h40)] = 32'h2002000A; ref_mem[idx(32'h40)] = 32'h2002000A;
    ram_mem[idx(FA)]     = 32'h1111_2222; ref_mem[idx(FA)]     = 32'h1111_2222;
    ram_mem[idx(LA)]     = 32'h3333_4444; ref_mem[idx(LA)]     = 32'h3333_4444;

    rst = 1; clear_reqs();
    if_addr = 32'h20; mem_addr = 32'h10; mem_wdata = 32'hA5A5_0001; ram_rdata = '0;
    step();
    mon_en = 1;

    // reset held with both requests high, then store wins on release
    if_req = 1; mem_write = 1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_if_valid", if_valid, 0);
      chk("rst_state", dbg_state, 0);
      chk("rst_ram_addr", ram_addr, 0);
      step();
    end
    rst = 0;
    @(negedge clk);
    chk("rel_store_en", {ram_en, ram_we}, 2'b11);
    chk("rel_store_addr", ram_addr, 32'h10);
    chk("rel_store_valid", mem_valid, 1);
    step();
    settle(LAT + 2);

    // table of single-cycle grant decisions from idle
    for (int i = 0; i < 8; i++) begin
      if_req = vecs[i].if_req; mem_read = vecs[i].rd; mem_write = vecs[i].wr;
      if_flush = vecs[i].flush; if_addr = IF_A; mem_addr = MEM_A; mem_wdata = 32'hC0DE_0000 + i;
      @(negedge clk);
      chk($sformatf("vec%0d_en", i), ram_en, vecs[i].e_en);
      chk($sformatf("vec%0d_we", i), ram_we, vecs[i].e_we);
      chk($sformatf("vec%0d_mv", i), mem_valid, vecs[i].e_mv);
      chk($sformatf("vec%0d_stall", i), pipe_stall, vecs[i].e_stall);
      chk($sformatf("vec%0d_keep", i), pc_keep, vecs[i].e_keep);
      if (vecs[i].e_en) chk($sformatf("vec%0d_addr", i), ram_addr, vecs[i].e_addr);
      step();
      settle(LAT + 1);
    end

    // fetch only at 0x40
    if_req = 1; if_addr = 32'h40;
    @(negedge clk); chk("f_issue_en", ram_en, 1); chk("f_keep_t0", pc_keep, 1);
    step();
    @(negedge clk); chk("f_keep_t1", pc_keep, 1); chk("f_valid_t1", if_valid, 0);
    step();
    @(negedge clk); chk("f_valid_t2", if_valid, 1); chk("f_rdata_t2", if_rdata, 32'h2002000A);
    chk("f_keep_t2", pc_keep, 0);
    step(); settle(2);

    // load and fetch raised together
    mem_read = 1; mem_addr = LA; if_req = 1; if_addr = FA;
    @(negedge clk); chk("lf_load_issue", {ram_en, ram_we}, 2'b10); chk("lf_addr_t0", ram_addr, LA);
    chk("lf_stall_t0", pipe_stall, 1);
    step();
    @(negedge clk); chk("lf_stall_t1", pipe_stall, 1); chk("lf_en_t1", ram_en, 0);
    step();
    @(negedge clk); chk("lf_mv_t2", mem_valid, 1); chk("lf_stall_t2", pipe_stall, 0);
    chk("lf_mrd_t2", mem_rdata, 32'h3333_4444);
    step(); mem_read = 0;
    @(negedge clk); chk("lf_fetch_t3", ram_en, 1); chk("lf_faddr_t3", ram_addr, FA);
    step(); step();
    @(negedge clk); chk("lf_iv_t5", if_valid, 1); chk("lf_ird_t5", if_rdata, 32'h1111_2222);
    step(); settle(2);

    // load arrives while a fetch is in flight
    if_req = 1; if_addr = FA;
    @(negedge clk); chk("fl_fetch_t0", ram_en, 1);
    step(); mem_read = 1; mem_addr = LA;
    @(negedge clk); chk("fl_stall_t1", pipe_stall, 1); chk("fl_en_t1", ram_en, 0);
    step();
    @(negedge clk); chk("fl_iv_t2", if_valid, 1); chk("fl_stall_t2", pipe_stall, 1);
    step(); if_req = 0;
    @(negedge clk); chk("fl_issue_t3", ram_en, 1); chk("fl_addr_t3", ram_addr, LA);
    chk("fl_stall_t3", pipe_stall, 1);
    step();
    @(negedge clk); chk("fl_stall_t4", pipe_stall, 1); chk("fl_mv_t4", mem_valid, 0);
    step();
    @(negedge clk); chk("fl_mv_t5", mem_valid, 1); chk("fl_stall_t5", pipe_stall, 0);
    step(); settle(2);

    // flush during a fetch
    if_req = 1; if_addr = 32'h40;
    step(); if_flush = 1;
    step(); if_flush = 0;
    @(negedge clk); chk("fx_no_iv_t2", if_valid, 0);
    step();
    @(negedge clk); chk("fx_reissue_t3", ram_en, 1); chk("fx_addr_t3", ram_addr, 32'h40);
    step(); step();
    @(negedge clk); chk("fx_iv_t5", if_valid, 1);
    step(); settle(2);

    // reset during a load
    mem_read = 1; mem_addr = LA;
    step(); rst = 1;
    @(negedge clk); chk("rl_mv_t1", mem_valid, 0);
    step(); rst = 0; mem_read = 0;
    @(negedge clk); chk("rl_mv_t2", mem_valid, 0); chk("rl_state_t2", dbg_state, 0);
    chk("rl_mrd_t2", mem_rdata, 0); chk("rl_en_t2", ram_en, 0);
    step(); settle(2);

    // randomized traffic checked by the reference model
    d_act = 0; f_act = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      saw_mv = mem_valid; saw_iv = if_valid;
      step();
      rst = ($urandom_range(0, 149) == 0);
      if (d_act && saw_mv) begin
        d_act = 0; mem_read = 0; mem_write = 0;
      end else if (!d_act && $urandom_range(0, 3) == 0) begin
        int k;
        d_act = 1; k = $urandom_range(0, 2);
        mem_read = (k != 1); mem_write = (k != 0);
        mem_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        mem_wdata = $urandom;
      end
      if_flush = ($urandom_range(0, 7) == 0);
      if (f_act && saw_iv) begin
        f_act = 0; if_req = 0;
      end else if (f_act && if_flush) begin
        if_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      end else if (!f_act && $urandom_range(0, 2) == 0) begin
        f_act = 1; if_req = 1;
        if_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      end
    end
    rst = 0;
    settle(LAT + 3);
    mon_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
